// File: rtl/weight_load_pkg.sv
// Shared definitions for the weight buffer loader.
//   state_t             : loader FSM states (also exported as a debug output)
//   DEF_ADDR_WIDTH      : default weight buffer word-address width
//   DEF_DATA_WIDTH      : default buffer word width (one 3x3 kernel of 16-bit taps)
//   DEF_BYTES_PER_WORD  : default bytes packed into one buffer word
package weight_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 144;
  localparam int DEF_BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into buffer words, first byte in the LSBs.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears word and counter)
//   shift_en   : a byte is transferred this cycle
//   in_data    : byte being transferred
//   word       : packed word register (the single word of storage)
//   word_done  : high in the cycle the last byte of a word is transferred
module byte_word_packer
  import weight_load_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [7:0]            in_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [CW-1:0] byte_cnt;

  assign word_done = shift_en && (byte_cnt == CW'(BYTES_PER_WORD - 1));

  // Bytes enter at the top and shift down, so after a full word byte k
  // sits at [8k+7:8k]. Assumes DATA_WIDTH == 8 * BYTES_PER_WORD.
  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {in_data, word[DATA_WIDTH-1:8]};
      byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/weight_buf_loader.sv
// Loads word_count+1 words of weights from a byte stream into the weight
// buffer write port, one packed word per wr_en strobe at consecutive
// addresses starting at 0.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (aborts any load)
//   start         : one-cycle load request, only honoured in IDLE
//   word_count    : words to load minus one, captured with start
//   in_data       : weight byte stream
//   in_valid      : in_data valid
//   in_ready      : loader accepts a byte this cycle
//   wr_en         : buffer write strobe, one cycle per word
//   wr_addr       : buffer write address
//   wr_data       : packed buffer word
//   busy          : load in progress (cycle after start through DONE)
//   done          : one-cycle pulse after the last word is written
//   state         : current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is registered and is high only in COLLECT; the
// source may hold in_valid high at any time without a byte being consumed.
module weight_buf_loader
  import weight_load_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output state_t                state
);

  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  shift_en;
  logic                  word_done;

  assign shift_en = in_valid && in_ready;

  // wr_data is the packer's word register directly; it is stable during
  // WRITE because in_ready is low there.
  byte_word_packer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .in_data   (in_data),
    .word      (wr_data),
    .word_done (word_done)
  );

  // wr_addr doubles as the word counter: the load ends when the word just
  // written sits at the captured count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      last_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_COLLECT;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            wr_addr   <= '0;
            last_addr <= word_count;
          end
        end
        ST_COLLECT: begin
          if (word_done) begin
            state    <= ST_WRITE;
            in_ready <= 1'b0;
            wr_en    <= 1'b1;
          end
        end
        ST_WRITE: begin
          wr_en <= 1'b0;
          if (wr_addr == last_addr) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state    <= ST_COLLECT;
            in_ready <= 1'b1;
            wr_addr  <= wr_addr + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          wr_en    <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/weight_buf_loader.md
WEIGHT_BUF_LOADER -- requirements
Module: weight_buf_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, weight buffer word-address width.
REQ-002 Parameter DATA_WIDTH, default 144, weight buffer word width (one 3x3 kernel, 9 x 16-bit).
REQ-003 Parameter BYTES_PER_WORD, default DATA_WIDTH/8 = 18, bytes packed per buffer word.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle load request, sampled only in IDLE.
REQ-007 word_count  input  ADDR_WIDTH  number of words to load minus 1 (0 -> 1 word, 255 -> 256 words), captured with start.
REQ-008 in_data  input  8  weight byte stream.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  loader accepts byte this cycle; transfer when in_valid and in_ready both high.
REQ-011 wr_en  output  1  buffer write strobe, one cycle per word.
REQ-012 wr_addr  output  ADDR_WIDTH  buffer write address.
REQ-013 wr_data  output  DATA_WIDTH  packed buffer word.
REQ-014 busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-015 done  output  1  one-cycle pulse after the last word is written.

Function
REQ-016 FSM states IDLE, COLLECT, WRITE, DONE; IDLE->COLLECT on start; COLLECT->WRITE when byte BYTES_PER_WORD-1 of a word is accepted; WRITE->COLLECT if words remain, else WRITE->DONE; DONE->IDLE unconditionally.
REQ-017 in_ready SHALL be high only in COLLECT; bytes presented in IDLE, WRITE or DONE SHALL not be consumed.
REQ-018 Byte k (0-based) of a word SHALL occupy wr_data[8k+7:8k] (first byte in LSBs).
REQ-019 wr_en SHALL be high exactly during the WRITE state, one cycle after the final byte of the word is accepted; wr_data and wr_addr stable that cycle.
REQ-020 wr_addr SHALL be 0 for the first word of a load and increment by 1 per word; no wrap within a load (max 256 words at ADDR_WIDTH 8).
REQ-021 Byte counter SHALL reset to 0 after each word; word counter SHALL compare against captured word_count to select DONE.
REQ-022 start asserted while busy SHALL be ignored; word_count changes after capture SHALL have no effect.
REQ-023 Gaps on in_valid SHALL stall packing without loss or duplication; throughput max one word per BYTES_PER_WORD+1 cycles.
REQ-024 done SHALL be high exactly one cycle (DONE state); a new start is accepted the following cycle (IDLE).

Reset
REQ-025 On rst: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, byte/word counters 0.
REQ-026 rst during any state SHALL abort the load with no further wr_en; a partially packed word SHALL be discarded.
REQ-027 rst SHALL take priority over start and in_valid in the same cycle.

Structure
REQ-028 Package weight_load_pkg SHALL hold the state enum and default ADDR_WIDTH/DATA_WIDTH/BYTES_PER_WORD constants.
REQ-029 A single sub-module byte_word_packer (byte shift-in, byte counter, word-complete flag) is natural; FSM and address counter stay in the top.
REQ-030 Outputs SHALL connect directly to the write port of the 256x144 weight buffer read by the convolution engine; no internal storage beyond one word register.

Verification
REQ-031 start with word_count=0, 18 bytes 0x01..0x12 back-to-back -> one wr_en, wr_addr=0, wr_data=0x12111...0201, done one cycle later, busy then 0.
REQ-032 word_count=255, 4608 incrementing bytes -> 256 writes, addresses 0..255 in order, each word correct, single done pulse.
REQ-033 word_count=1, in_valid toggled 1/0 every cycle -> 2 writes with correct data, in_ready low during WRITE, no byte lost.
REQ-034 start pulsed again mid-load with word_count=7 -> ignored, load finishes with original count.
REQ-035 rst asserted after 10 bytes of word 2 -> no further wr_en, all outputs at reset values next cycle; new start then loads from wr_addr 0.
REQ-036 in_valid high while IDLE, no start -> in_ready 0, wr_en never asserted.
